// File: rtl/entry_pkg.sv
// Shared types and limits for the decimal entry block.
package entry_pkg;
    typedef enum logic [2:0] {S_IDLE, S_ENTRY, S_CHECK, S_DONE, S_ERR} state_e;

    localparam int MAG_W = 10;
    localparam logic [MAG_W-1:0] MAX_POS = 10'd127;
    localparam logic [MAG_W-1:0] MAX_NEG = 10'd128;
endpackage

// File: rtl/mag_accumulator.sv
// Combinational decimal shift-in: mag*10 + digit using shift-and-add.
module mag_accumulator
    import entry_pkg::*;
(
    input  logic [MAG_W-1:0] mag_i,
    input  logic [3:0]       digit_i,
    output logic [MAG_W-1:0] nxt_o
);
    assign nxt_o = (mag_i << 3) + (mag_i << 1) + {{(MAG_W-4){1'b0}}, digit_i};
endmodule

// File: rtl/decimal_entry_unit.sv
// Keypad-style decimal entry: collects sign + up to MAX_DIGITS digits and
// converts to signed 8-bit with range checking.
module decimal_entry_unit
    import entry_pkg::*;
#(
    parameter int MAX_DIGITS = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       digit_valid,
    input  logic [3:0] digit,
    input  logic       sign_toggle,
    input  logic       enter,
    input  logic       clear,
    output logic [7:0] value,
    output logic       value_valid,
    output logic       err,
    output logic       sign_out,
    output logic [3:0] hundreds_out,
    output logic [3:0] tens_out,
    output logic [3:0] ones_out,
    output logic [1:0] digit_count
);
    state_e           state_q, state_d;
    logic [MAG_W-1:0] mag_q, mag_d, acc_nxt;
    logic [3:0]       hund_q, hund_d, tens_q, tens_d, ones_q, ones_d;
    logic             sign_q, sign_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [7:0]       value_q, value_d;
    logic             vvalid_q, vvalid_d;
    logic             finished, room, digit_ok, in_range;

    mag_accumulator u_acc (
        .mag_i   (mag_q),
        .digit_i (digit),
        .nxt_o   (acc_nxt)
    );

    assign finished = (state_q == S_DONE) || (state_q == S_ERR);
    assign room     = int'(cnt_q) < MAX_DIGITS;
    assign digit_ok = digit <= 4'd9;
    assign in_range = sign_q ? (mag_q <= MAX_NEG) : (mag_q <= MAX_POS);

    always_comb begin
        state_d  = state_q;
        mag_d    = mag_q;
        hund_d   = hund_q;
        tens_d   = tens_q;
        ones_d   = ones_q;
        sign_d   = sign_q;
        cnt_d    = cnt_q;
        value_d  = value_q;
        vvalid_d = 1'b0;
        if (state_q == S_CHECK) begin
            // Inputs are deliberately ignored here, including clear.
            if (in_range) begin
                value_d  = sign_q ? (~mag_q[7:0]) + 8'd1 : mag_q[7:0];
                vvalid_d = 1'b1;
                state_d  = S_DONE;
            end else begin
                state_d  = S_ERR;
            end
        end else if (clear) begin
            mag_d   = '0;
            hund_d  = '0;
            tens_d  = '0;
            ones_d  = '0;
            sign_d  = 1'b0;
            cnt_d   = '0;
            state_d = S_IDLE;
        end else if (enter) begin
            if (!finished) state_d = S_CHECK;
        end else if (sign_toggle) begin
            if (finished) begin
                mag_d   = '0;
                hund_d  = '0;
                tens_d  = '0;
                ones_d  = '0;
                cnt_d   = '0;
                sign_d  = 1'b1;
                state_d = S_IDLE;
            end else begin
                sign_d  = ~sign_q;
            end
        end else if (digit_valid && digit_ok) begin
            if (finished) begin
                mag_d   = {{(MAG_W-4){1'b0}}, digit};
                hund_d  = '0;
                tens_d  = '0;
                ones_d  = digit;
                cnt_d   = 2'd1;
                sign_d  = 1'b0;
                state_d = S_ENTRY;
            end else if (room) begin
                mag_d   = acc_nxt;
                hund_d  = tens_q;
                tens_d  = ones_q;
                ones_d  = digit;
                cnt_d   = cnt_q + 2'd1;
                state_d = S_ENTRY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            mag_q    <= '0;
            hund_q   <= '0;
            tens_q   <= '0;
            ones_q   <= '0;
            sign_q   <= 1'b0;
            cnt_q    <= '0;
            value_q  <= '0;
            vvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            mag_q    <= mag_d;
            hund_q   <= hund_d;
            tens_q   <= tens_d;
            ones_q   <= ones_d;
            sign_q   <= sign_d;
            cnt_q    <= cnt_d;
            value_q  <= value_d;
            vvalid_q <= vvalid_d;
        end
    end

    assign value        = value_q;
    assign value_valid  = vvalid_q;
    assign err          = (state_q == S_ERR);
    assign sign_out     = sign_q;
    assign hundreds_out = hund_q;
    assign tens_out     = tens_q;
    assign ones_out     = ones_q;
    assign digit_count  = cnt_q;
endmodule
